// File: rtl/vec_feeder.sv
// ---------------------------------------------------------------------------
// vec_feeder
//
// Upstream stage of the ELM engine's 256-bit vector deserializer. A start
// command reads num_vec consecutive vectors of WORDS words each from a
// synchronous memory. Each vector goes out as an unbroken burst of rx strobes
// with a descending count. The block then waits for the deserializer's tx
// pulse before it fetches the next vector.
//
// Optional feature: define VEC_FEEDER_TIMEOUT_EN to bound the tx wait to
// ACK_TIMEOUT cycles. On expiry, err is set, the remaining vectors are
// dropped, and done still pulses. Without the macro the wait is unbounded and
// err is tied low.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 start request, sampled in IDLE only
//   base_addr [ADDR_W]    word address of vector 0, word 0
//   num_vec   [8]         number of vectors to send (0 = immediate done)
//   busy                  transfer in progress
//   done                  one-cycle end-of-transfer pulse
//   err                   sticky ack-timeout flag, cleared by an accepted start
//   mem_en, mem_addr      memory read request
//   mem_rdata [WORD_W]    read data, valid one cycle after mem_en
//   serial_data [WORD_W]  word to the deserializer
//   count [5]             words remaining in the vector (31 when idle)
//   rx                    word strobe
//   tx                    vector-complete pulse from the deserializer
// ---------------------------------------------------------------------------
module vec_feeder #(
  parameter int unsigned WORD_W      = 16,
  parameter int unsigned WORDS       = 16,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        num_vec,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] serial_data,
  output logic [4:0]        count,
  output logic              rx,
  input  logic              tx
);

  localparam int unsigned    IDX_W     = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [4:0]     CNT_IDLE  = 5'd31;
  localparam logic [4:0]     CNT_FIRST = 5'(WORDS - 1);

  // The vector must fill the 256-bit deserializer exactly.
  if ((WORD_W * WORDS != 256) || (ACK_TIMEOUT < 1)) begin : g_bad_cfg
    $error("vec_feeder: WORD_W*WORDS must be 256 and ACK_TIMEOUT at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WAIT_ACK,
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        vec_left_q, vec_left_d;
  logic [IDX_W-1:0]  fetch_idx_q, fetch_idx_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rx_q, rx_d;
  logic [4:0]        count_q, count_d;
  logic [WORD_W-1:0] sdata_q, sdata_d;
  logic              ack_timeout;

`ifdef VEC_FEEDER_TIMEOUT_EN
  localparam int unsigned ACK_CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [ACK_CNT_W-1:0] ACK_LAST = ACK_CNT_W'(ACK_TIMEOUT - 1);

  logic [ACK_CNT_W-1:0] ack_cnt_q, ack_cnt_d;
  logic                 err_q, err_d;

  // The counter restarts on every WAIT_ACK entry. Its last value is the
  // ACK_TIMEOUT-th waiting cycle. A tx arriving in that same cycle still wins.
  assign ack_timeout = (state_q == S_WAIT_ACK) && !tx && (ack_cnt_q == ACK_LAST);

  always_comb begin
    ack_cnt_d = '0;
    if (state_q == S_WAIT_ACK) ack_cnt_d = ack_cnt_q + ACK_CNT_W'(1);
  end

  always_comb begin
    err_d = err_q;
    if (state_q == S_IDLE && start) err_d = 1'b0;
    else if (ack_timeout)           err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      ack_cnt_q <= ack_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err = err_q;
`else
  assign ack_timeout = 1'b0;
  assign err         = 1'b0;
`endif

  // Control FSM: address generation and vector bookkeeping
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    vec_left_d  = vec_left_q;
    fetch_idx_d = fetch_idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_vec != '0) begin
            addr_d      = base_addr;
            vec_left_d  = num_vec;
            fetch_idx_d = '0;
            state_d     = S_FETCH;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_FETCH: begin
        // The address wraps silently at 2^ADDR_W.
        addr_d      = addr_q + ADDR_W'(1);
        fetch_idx_d = fetch_idx_q + IDX_W'(1);
        if (fetch_idx_q == LAST_IDX) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (rx_q && (count_q == '0)) state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (tx) begin
          vec_left_d = vec_left_q - 8'd1;
          if (vec_left_q == 8'd1) begin
            state_d = S_FIN;
          end else begin
            fetch_idx_d = '0;
            state_d     = S_FETCH;
          end
        end else if (ack_timeout) begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read-data alignment and output register (read issue -> data -> rx)
  always_comb begin
    rd_vld_d = (state_q == S_FETCH);
    rx_d     = rd_vld_q;
    sdata_d  = rd_vld_q ? mem_rdata : sdata_q;
    count_d  = count_q;
    if (rd_vld_q) begin
      count_d = rx_q ? (count_q - 5'd1) : CNT_FIRST;
    end else if ((state_d == S_IDLE) || (state_d == S_FIN) ||
                 ((state_q == S_WAIT_ACK) && (state_d == S_FETCH))) begin
      // Park at 31 outside a burst. A count of 0 would look like a finished
      // vector to the deserializer.
      count_d = CNT_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      vec_left_q  <= '0;
      fetch_idx_q <= '0;
      rd_vld_q    <= 1'b0;
      rx_q        <= 1'b0;
      count_q     <= CNT_IDLE;
      sdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      vec_left_q  <= vec_left_d;
      fetch_idx_q <= fetch_idx_d;
      rd_vld_q    <= rd_vld_d;
      rx_q        <= rx_d;
      count_q     <= count_d;
      sdata_q     <= sdata_d;
    end
  end

  assign busy        = (state_q == S_FETCH) || (state_q == S_DRAIN) || (state_q == S_WAIT_ACK);
  assign done        = (state_q == S_FIN);
  assign mem_en      = (state_q == S_FETCH);
  assign mem_addr    = addr_q;
  assign serial_data = sdata_q;
  assign count       = count_q;
  assign rx          = rx_q;

endmodule
